// File: rtl/rounding_pipe.sv
// Multi-lane, two-stage rounding unit with valid/ready handshake.
// S1 captures operands; S2 is the output register holding rounded results and flags.

module rounding_lane #(
  parameter int WIDTH = 24
) (
  input  logic [WIDTH-1:0] i_d,
  input  logic             i_sign,
  input  logic             i_rnd,
  input  logic             i_stk,
  input  logic             i_mask,
  input  logic [2:0]       i_rm,
  output logic [WIDTH-1:0] o_data,
  output logic             o_cout,
  output logic             o_inexact
);
  localparam logic [2:0] RM_RNE = 3'd0;
  localparam logic [2:0] RM_RDN = 3'd2;
  localparam logic [2:0] RM_RUP = 3'd3;
  localparam logic [2:0] RM_RMM = 3'd4;
  localparam logic [2:0] RM_ROD = 3'd5;

  logic             w_up;
  logic [WIDTH:0]   w_inc;
  logic [WIDTH-1:0] w_rod;

  always_comb begin
    w_up = 1'b0;
    case (i_rm)
      RM_RNE:  w_up = i_rnd & (i_stk | i_d[0]);
      RM_RDN:  w_up = (i_rnd | i_stk) & i_sign;
      RM_RUP:  w_up = (i_rnd | i_stk) & ~i_sign;
      RM_RMM:  w_up = i_rnd;
      default: w_up = 1'b0;
    endcase
    if (!i_mask) w_up = 1'b0;
  end

  // One extra bit so the increment overflow surfaces as carry-out.
  assign w_inc     = {1'b0, i_d} + {{WIDTH{1'b0}}, w_up};
  assign w_rod     = {i_d[WIDTH-1:1], i_d[0] | i_rnd | i_stk};
  assign o_data    = (i_mask && i_rm == RM_ROD) ? w_rod : w_inc[WIDTH-1:0];
  assign o_cout    = w_inc[WIDTH];
  assign o_inexact = (i_rnd | i_stk) & i_mask;
endmodule

module rounding_pipe #(
  parameter int WIDTH = 24,
  parameter int LANES = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LANES*WIDTH-1:0] in_data,
  input  logic [LANES-1:0]       in_sign,
  input  logic [LANES-1:0]       in_round,
  input  logic [LANES-1:0]       in_sticky,
  input  logic [LANES-1:0]       in_mask,
  input  logic [2:0]             in_rm,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*WIDTH-1:0] out_data,
  output logic [LANES-1:0]       out_cout,
  output logic [LANES-1:0]       out_inexact,
  output logic                   out_rm_err,
  input  logic                   flag_clr,
  output logic                   nx_acc
);
  localparam int         STAGES = 2;
  localparam logic [2:0] RM_RTZ = 3'd1;

  typedef struct packed {
    logic [LANES-1:0][WIDTH-1:0] data;
    logic [LANES-1:0]            sign;
    logic [LANES-1:0]            rnd;
    logic [LANES-1:0]            stk;
    logic [LANES-1:0]            mask;
    logic [2:0]                  rm;
    logic                        err;
  } s1_t;

  logic [STAGES:1]             r_vld_pipe;
  s1_t                         r_s1;
  logic [LANES-1:0][WIDTH-1:0] r_s2_data;
  logic [LANES-1:0]            r_s2_cout;
  logic [LANES-1:0]            r_s2_nx;
  logic                        r_s2_err;
  logic                        r_nx_acc;

  logic [LANES-1:0][WIDTH-1:0] w_data;
  logic [LANES-1:0]            w_cout;
  logic [LANES-1:0]            w_nx;
  logic                        w_in_ready;
  logic                        w_acc;
  logic                        w_adv;
  logic                        w_hand;
  logic                        w_rm_bad;

  assign w_in_ready = !r_vld_pipe[1] || !r_vld_pipe[2] || out_ready;
  assign w_acc      = in_valid && w_in_ready;
  assign w_adv      = r_vld_pipe[1] && (!r_vld_pipe[2] || out_ready);
  assign w_hand     = r_vld_pipe[2] && out_ready;
  assign w_rm_bad   = (in_rm[2:1] == 2'b11);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_vld_pipe <= '0;
    else begin
      r_vld_pipe[1] <= w_acc | (r_vld_pipe[1] & ~w_adv);
      r_vld_pipe[2] <= w_adv | (r_vld_pipe[2] & ~out_ready);
    end
  end

  // Illegal modes are folded to RTZ at capture so lanes only see legal encodings.
  always_ff @(posedge clk) begin
    if (w_acc) begin
      r_s1.data <= in_data;
      r_s1.sign <= in_sign;
      r_s1.rnd  <= in_round;
      r_s1.stk  <= in_sticky;
      r_s1.mask <= in_mask;
      r_s1.rm   <= w_rm_bad ? RM_RTZ : in_rm;
      r_s1.err  <= w_rm_bad;
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    rounding_lane #(.WIDTH(WIDTH)) u_lane (
      .i_d       (r_s1.data[g]),
      .i_sign    (r_s1.sign[g]),
      .i_rnd     (r_s1.rnd[g]),
      .i_stk     (r_s1.stk[g]),
      .i_mask    (r_s1.mask[g]),
      .i_rm      (r_s1.rm),
      .o_data    (w_data[g]),
      .o_cout    (w_cout[g]),
      .o_inexact (w_nx[g])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s2_data <= '0;
      r_s2_cout <= '0;
      r_s2_nx   <= '0;
      r_s2_err  <= 1'b0;
    end else if (w_adv) begin
      r_s2_data <= w_data;
      r_s2_cout <= w_cout;
      r_s2_nx   <= w_nx;
      r_s2_err  <= r_s1.err;
    end
  end

  // A handoff overrides a coincident clear so its inexact is never lost.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           r_nx_acc <= 1'b0;
    else if (w_hand)   r_nx_acc <= (flag_clr ? 1'b0 : r_nx_acc) | (|r_s2_nx);
    else if (flag_clr) r_nx_acc <= 1'b0;
  end

  assign in_ready    = w_in_ready;
  assign out_valid   = r_vld_pipe[2];
  assign out_data    = r_s2_data;
  assign out_cout    = r_s2_cout;
  assign out_inexact = r_s2_nx;
  assign out_rm_err  = r_s2_err;
  assign nx_acc      = r_nx_acc;
endmodule
